// File: rtl/dbb_pkg.sv
// Shared definitions for the DBB tile scheduler.
//   sched_state_t     : scheduler FSM encoding (3-bit)
//   DBB_NUM_BLOCKS    : default number of density-bound blocks per row
//   DBB_TIMEOUT_CYC   : default watchdog limit for the SA wait
package dbb_pkg;

  localparam int DBB_NUM_BLOCKS  = 8;
  localparam int DBB_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/dbb_wdt.sv
// Watchdog up-counter for the SA wait.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clr        : synchronous clear to zero (highest priority)
//   i_load       : synchronous load of i_load_val
//   i_load_val   : value loaded when i_load is high
//   i_en         : count enable
//   o_expired    : counter has reached TIMEOUT_CYC-1
module dbb_wdt
  import dbb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DBB_TIMEOUT_CYC,
  parameter int W           = $clog2(TIMEOUT_CYC)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/dbb_tile_scheduler.sv
// Sequences the systolic array across one row of NUM_BLOCKS DBB blocks.
// A per-block mask is latched on start; zero blocks are skipped at one
// block per cycle, non-zero blocks get an SA start pulse and a guarded wait
// for SA done.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_start      : row start request (accepted only when idle)
//   i_mask_vec   : bit k set = compute block k (sampled with accepted start)
//   i_sa_done    : SA finished current block (honoured only while waiting)
//   o_sa_start   : one-cycle SA start pulse
//   o_blk_idx    : index of the block being issued/computed
//   o_busy       : high whenever not idle
//   o_done       : one-cycle row-finished pulse (normal or timeout)
//   o_err        : sticky watchdog timeout flag
//   o_nnz_cnt    : blocks issued in the last/current row
//   o_skip_cnt   : blocks skipped in the last/current row
module dbb_tile_scheduler
  import dbb_pkg::*;
#(
  parameter int NUM_BLOCKS  = DBB_NUM_BLOCKS,
  parameter int IDX_W       = $clog2(NUM_BLOCKS),
  parameter int CNT_W       = $clog2(NUM_BLOCKS + 1),
  parameter int TIMEOUT_CYC = DBB_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [NUM_BLOCKS-1:0] i_mask_vec,
  input  logic                  i_sa_done,
  output logic                  o_sa_start,
  output logic [IDX_W-1:0]      o_blk_idx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [CNT_W-1:0]      o_nnz_cnt,
  output logic [CNT_W-1:0]      o_skip_cnt
);

  localparam int               TW       = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  sched_state_t          r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_BLOCKS-1:0] r_mask;
  logic [CNT_W-1:0]      r_nnz;
  logic [CNT_W-1:0]      r_skip;
  logic                  r_err;

  logic w_last;
  logic w_cur_bit;
  logic w_wdt_clr;
  logic w_wdt_en;
  logic w_wdt_exp;

  assign w_last    = (r_idx == LAST_IDX);
  assign w_cur_bit = r_mask[r_idx];

  // The timer restarts at every issue; it only advances while the SA is
  // still busy, so a done in the expiry cycle is never overridden.
  assign w_wdt_clr = (r_state == ST_ISSUE) || ((r_state == ST_IDLE) && i_start);
  assign w_wdt_en  = (r_state == ST_WAIT) && !i_sa_done;

  dbb_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .W           (TW)
  ) u_wdt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_wdt_clr),
    .i_load     (1'b0),
    .i_load_val ({TW{1'b0}}),
    .i_en       (w_wdt_en),
    .o_expired  (w_wdt_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_mask  <= '0;
      r_nnz   <= '0;
      r_skip  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mask  <= i_mask_vec;
            r_idx   <= '0;
            r_nnz   <= '0;
            r_skip  <= '0;
            r_err   <= 1'b0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_cur_bit) begin
            r_state <= ST_ISSUE;
          end else begin
            r_skip <= r_skip + CNT_W'(1);
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          r_nnz   <= r_nnz + CNT_W'(1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_sa_done) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_SCAN;
            end
          end else if (w_wdt_exp) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_sa_start = (r_state == ST_ISSUE);
  assign o_done     = (r_state == ST_DONE);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_blk_idx  = r_idx;
  assign o_err      = r_err;
  assign o_nnz_cnt  = r_nnz;
  assign o_skip_cnt = r_skip;

endmodule

// File: tb/tb_dbb_tile_scheduler.sv
module tb_dbb_tile_scheduler;

  localparam int NB  = 8;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_mask_vec;
  logic       i_sa_done;
  logic       o_sa_start;
  logic [2:0] o_blk_idx;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [3:0] o_nnz_cnt;
  logic [3:0] o_skip_cnt;

  int checks = 0;
  int errors = 0;

  dbb_tile_scheduler #(
    .NUM_BLOCKS  (NB),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_mask_vec (i_mask_vec),
    .i_sa_done  (i_sa_done),
    .o_sa_start (o_sa_start),
    .o_blk_idx  (o_blk_idx),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_nnz_cnt  (o_nnz_cnt),
    .o_skip_cnt (o_skip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] mask;
    int         dly;      // cycles from start pulse to SA done; -1 = never
    int         cyc;      // cycles from start request to o_done
    int         pulses;
    logic [7:0] map;      // indices that must receive a start pulse
    int         nnz;
    int         skip;
    int         err;
  } row_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic run_row(input row_t v);
    int         cyc = -1;
    int         pulses = 0;
    int         ctr = 0;
    int         last = -1;
    bit         pend = 0;
    bit         order_ok = 1;
    bit         busy_ok = 1;
    bit         idx_ok = 1;
    bit         err_pre = 0;
    logic [7:0] map = '0;
    logic [2:0] cur_idx = '0;
    i_mask_vec = v.mask;
    i_start    = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      step();
      i_start   = 1'b0;
      i_sa_done = 1'b0;
      if (!o_busy) busy_ok = 0;
      if (o_done) begin
        cyc = c;
        break;
      end
      if (o_err) err_pre = 1;
      if (pend) begin
        ctr--;
        if (ctr == 0) begin
          pend      = 0;
          i_sa_done = 1'b1;
          if (o_blk_idx != cur_idx) idx_ok = 0;
        end
      end
      if (o_sa_start) begin
        pulses++;
        map[o_blk_idx] = 1'b1;
        if (int'(o_blk_idx) <= last) order_ok = 0;
        last    = int'(o_blk_idx);
        cur_idx = o_blk_idx;
        if (v.dly > 0) begin
          pend = 1;
          ctr  = v.dly;
        end
      end
    end
    i_sa_done = 1'b0;
    chk({v.nm, "_done_cycle"}, cyc, v.cyc);
    if (cyc < 0) begin
      $display("FAIL %s_no_done actual=none required=o_done", v.nm);
      return;
    end
    chk({v.nm, "_pulses"}, pulses, v.pulses);
    chk({v.nm, "_issue_map"}, int'(map), int'(v.map));
    chk({v.nm, "_order"}, int'(order_ok), 1);
    chk({v.nm, "_busy_cont"}, int'(busy_ok), 1);
    chk({v.nm, "_idx_stable"}, int'(idx_ok), 1);
    chk({v.nm, "_err_early"}, int'(err_pre), 0);
    chk({v.nm, "_nnz"}, int'(o_nnz_cnt), v.nnz);
    chk({v.nm, "_skip"}, int'(o_skip_cnt), v.skip);
    chk({v.nm, "_err"}, int'(o_err), v.err);
    step();
    chk({v.nm, "_idle_after"}, int'(o_busy), 0);
    chk({v.nm, "_err_hold"}, int'(o_err), v.err);
    chk({v.nm, "_nnz_hold"}, int'(o_nnz_cnt), v.nnz);
  endtask

  row_t vec [8];
  row_t fresh;

  initial begin
    int   pulses;
    int   done_c;
    bit   nodone_ok;

    vec[0] = '{"zero",  8'h00,  1,  9, 0, 8'h00, 0, 8, 0};
    vec[1] = '{"m81",   8'h81,  3, 17, 2, 8'h81, 2, 6, 0};
    vec[2] = '{"mFF",   8'hFF,  1, 25, 8, 8'hFF, 8, 0, 0};
    vec[3] = '{"tmo",   8'h04, -1, 21, 1, 8'h04, 1, 2, 1};
    vec[4] = '{"clr",   8'h04,  2, 12, 1, 8'h04, 1, 7, 0};
    vec[5] = '{"coinc", 8'h01, 16, 26, 1, 8'h01, 1, 7, 0};
    vec[6] = '{"late",  8'h01, 17, 19, 1, 8'h01, 1, 0, 1};
    vec[7] = '{"m80",   8'h80,  1, 11, 1, 8'h80, 1, 7, 0};

    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_mask_vec = '0;
    i_sa_done  = 1'b0;
    step();
    step();
    chk("reset_outputs",
        int'({o_sa_start, o_blk_idx, o_busy, o_done, o_err, o_nnz_cnt, o_skip_cnt}), 0);
    rst_n = 1'b1;
    step();
    chk("post_reset_busy", int'(o_busy), 0);

    for (int i = 0; i < 8; i++) run_row(vec[i]);

    // Busy-time inputs with mask 8'h01 and SA done 3 cycles after the pulse.
    pulses     = 0;
    done_c     = -1;
    i_mask_vec = 8'h01;
    i_start    = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (o_sa_start) pulses++;
      if (o_done && done_c < 0) done_c = c;
      i_start    = (c == 3 || c == 4 || c == 13);
      i_mask_vec = i_start ? 8'hFF : 8'h00;
      i_sa_done  = (c == 1 || c == 2 || c == 5 || c == 6 || c == 8 || c == 14);
    end
    i_start   = 1'b0;
    i_sa_done = 1'b0;
    chk("busyin_pulses", pulses, 1);
    chk("busyin_done_cycle", done_c, 13);
    chk("busyin_nnz", int'(o_nnz_cnt), 1);
    chk("busyin_skip", int'(o_skip_cnt), 7);
    chk("busyin_idle", int'(o_busy), 0);

    // Reset asserted while waiting on block 2 of mask 8'h0F.
    i_mask_vec = 8'h0F;
    i_start    = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      i_start   = 1'b0;
      i_sa_done = (c == 3 || c == 6);
    end
    i_sa_done = 1'b0;
    chk("midrst_pre_idx", int'(o_blk_idx), 2);
    chk("midrst_pre_nnz", int'(o_nnz_cnt), 3);
    chk("midrst_pre_busy", int'(o_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_async_clear",
        int'({o_sa_start, o_blk_idx, o_busy, o_done, o_err, o_nnz_cnt, o_skip_cnt}), 0);
    step();
    rst_n     = 1'b1;
    nodone_ok = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (o_done || o_busy) nodone_ok = 0;
    end
    chk("midrst_idle_no_done", int'(nodone_ok), 1);
    fresh = '{"fresh", 8'h0F, 1, 17, 4, 8'h0F, 4, 4, 0};
    run_row(fresh);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
